// File: rtl/mioc_flop_seq.sv
`default_nettype none
// mioc_flop_seq: pattern sequencer that drives the MIOC NMOS flop cell and scores q/qbar. Rev 1.0.
// Optional macro MIOC_SEQ_STOP_ON_FAIL_EN ends the run at the first mismatch.
module mioc_flop_seq #(
  parameter int ADDR_W      = 8,
  parameter int HOLD_CYCLES = 100,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] num_pat,
  output logic              busy,
  output logic              done,
  output logic              pat_rd,
  output logic [ADDR_W-1:0] pat_addr,
  input  logic [5:0]        pat_data,
  output logic [3:0]        flop_in,
  input  logic              flop_q,
  input  logic              flop_qbar,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              first_fail_vld,
  output logic [ADDR_W-1:0] first_fail_addr
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_HOLD  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [15:0] c_HOLD_LOAD = 16'(HOLD_CYCLES - 1);

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_num_pat;
  logic [ADDR_W-1:0] r_index;
  logic [ADDR_W-1:0] r_pat_addr;
  logic [ADDR_W-1:0] r_ff_addr;
  logic [3:0]        r_flop_in;
  logic [1:0]        r_exp;
  logic [15:0]       r_hold_cnt;
  logic [CNT_W-1:0]  r_err_cnt;
  logic              r_ff_vld;
  logic              w_sample;
  logic              w_mismatch;
  logic              w_last;

  assign w_sample   = (r_state == S_HOLD) && (r_hold_cnt == 16'd0);
  assign w_mismatch = w_sample && ({flop_q, flop_qbar} != r_exp);
  // Widened compare so the last-pattern test is safe for num_pat at full scale.
  assign w_last     = ({1'b0, r_index} + (ADDR_W+1)'(1)) == {1'b0, r_num_pat};

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = (num_pat == '0) ? S_DONE : S_FETCH;
      S_FETCH: w_next = S_LOAD;
      S_LOAD:  w_next = S_HOLD;
      S_HOLD: begin
        if (w_sample) begin
`ifdef MIOC_SEQ_STOP_ON_FAIL_EN
          if (w_mismatch || w_last) w_next = S_DONE;
          else                      w_next = S_FETCH;
`else
          if (w_last) w_next = S_DONE;
          else        w_next = S_FETCH;
`endif
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_num_pat  <= '0;
      r_index    <= '0;
      r_pat_addr <= '0;
      r_ff_addr  <= '0;
      r_flop_in  <= '0;
      r_exp      <= '0;
      r_hold_cnt <= '0;
      r_err_cnt  <= '0;
      r_ff_vld   <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_num_pat <= num_pat;
            r_index   <= '0;
            r_err_cnt <= '0;
            r_ff_vld  <= 1'b0;
            r_ff_addr <= '0;
          end
        end
        S_LOAD: begin
          r_flop_in  <= pat_data[5:2];
          r_exp      <= pat_data[1:0];
          r_hold_cnt <= c_HOLD_LOAD;
        end
        S_HOLD: begin
          if (!w_sample) begin
            r_hold_cnt <= r_hold_cnt - 16'd1;
          end else begin
            if (w_mismatch) begin
              if (!(&r_err_cnt)) r_err_cnt <= r_err_cnt + CNT_W'(1);
              if (!r_ff_vld) begin
                r_ff_vld  <= 1'b1;
                r_ff_addr <= r_index;
              end
            end
            if (w_next == S_FETCH) r_index <= r_index + ADDR_W'(1);
          end
        end
        S_DONE:  r_flop_in <= '0;
        default: ;
      endcase
      // Address is registered on entry to FETCH so it holds between reads.
      if (w_next == S_FETCH) r_pat_addr <= (r_state == S_IDLE) ? '0 : r_index + ADDR_W'(1);
    end
  end

  assign busy            = (r_state == S_FETCH) || (r_state == S_LOAD) || (r_state == S_HOLD);
  assign done            = (r_state == S_DONE);
  assign pat_rd          = (r_state == S_FETCH);
  assign pat_addr        = r_pat_addr;
  assign flop_in         = r_flop_in;
  assign err_cnt         = r_err_cnt;
  assign first_fail_vld  = r_ff_vld;
  assign first_fail_addr = r_ff_addr;

endmodule
`default_nettype wire

// File: tb/tb_mioc_flop_seq.sv
`default_nettype none
// tb_mioc_flop_seq: randomized bench with a timeline-arithmetic reference model for mioc_flop_seq.
// Rev 1.0.
module tb_mioc_flop_seq;

  localparam int H      = 4;
  localparam int AW     = 4;
  localparam int CW     = 2;
  localparam int NP     = 1 << AW;
  localparam int SATMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] num_pat = '0;
  logic          busy;
  logic          done;
  logic          pat_rd;
  logic [AW-1:0] pat_addr;
  logic [5:0]    pat_data = '0;
  logic [3:0]    flop_in;
  logic          flop_q = 1'b0;
  logic          flop_qbar = 1'b0;
  logic [CW-1:0] err_cnt;
  logic          first_fail_vld;
  logic [AW-1:0] first_fail_addr;

  logic [5:0] rom  [NP];
  logic [1:0] resp [NP];
  int checks = 0;
  int errors = 0;
  int m_addr = 0;

  always #5 clk = ~clk;

  mioc_flop_seq #(.ADDR_W(AW), .HOLD_CYCLES(H), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_pat(num_pat),
    .busy(busy), .done(done), .pat_rd(pat_rd), .pat_addr(pat_addr),
    .pat_data(pat_data), .flop_in(flop_in), .flop_q(flop_q), .flop_qbar(flop_qbar),
    .err_cnt(err_cnt), .first_fail_vld(first_fail_vld), .first_fail_addr(first_fail_addr)
  );

  // Synchronous pattern memory; garbage on non-read cycles exposes late sampling.
  always @(posedge clk) pat_data <= pat_rd ? rom[pat_addr] : 6'($urandom);

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_pat_rd"}, int'(pat_rd), 0);
    chk({tag, "_pat_addr"}, int'(pat_addr), 0);
    chk({tag, "_flop_in"}, int'(flop_in), 0);
    chk({tag, "_err_cnt"}, int'(err_cnt), 0);
    chk({tag, "_ff_vld"}, int'(first_fail_vld), 0);
    chk({tag, "_ff_addr"}, int'(first_fail_addr), 0);
  endtask

  // One run: cycle t counts from 1 after the accepting edge; pattern p occupies
  // cycles p*(H+2)+1 .. (p+1)*(H+2) and is sampled in its last cycle.
  task automatic run(input int n, input int extra_t, input int rst_t, output int t_seen);
    bit fail [NP];
    int n_eff, t_done;
    n_eff  = n;
    t_seen = -1;
    for (int i = 0; i < NP; i++) fail[i] = (i < n) && (resp[i] != rom[i][1:0]);
`ifdef MIOC_SEQ_STOP_ON_FAIL_EN
    for (int i = n - 1; i >= 0; i--) if (fail[i]) n_eff = i + 1;
`endif
    t_done = n_eff * (H + 2) + 1;
    @(negedge clk);
    num_pat = AW'(n);
    start   = 1'b1;
    for (int t = 1; t <= t_done + 1; t++) begin
      int p, ph, e_err, e_ffv, e_ffa, e_flop;
      logic [5:0] w;
      @(negedge clk);
      start   = 1'b0;
      num_pat = AW'($urandom);
      p  = (t - 1) / (H + 2);
      ph = (t - 1) % (H + 2);
      e_err = 0; e_ffv = 0; e_ffa = 0;
      for (int j = 0; j < n_eff; j++) begin
        if (fail[j] && ((j + 1) * (H + 2) < t)) begin
          if (e_ffv == 0) begin e_ffv = 1; e_ffa = j; end
          e_err++;
        end
      end
      if (e_err > SATMAX) e_err = SATMAX;
      e_flop = 0;
      if (t < t_done) begin
        m_addr = p;
        if (ph >= 2) begin w = rom[p]; e_flop = int'(w[5:2]); end
        else if (p > 0) begin w = rom[p-1]; e_flop = int'(w[5:2]); end
      end else if (t == t_done && n_eff > 0) begin
        w = rom[n_eff-1];
        e_flop = int'(w[5:2]);
      end
      if (done && t_seen < 0) t_seen = t;
      chk("busy", int'(busy), int'(t < t_done));
      chk("done", int'(done), int'(t == t_done));
      chk("pat_rd", int'(pat_rd), int'(t < t_done && ph == 0));
      chk("pat_addr", int'(pat_addr), m_addr);
      chk("flop_in", int'(flop_in), e_flop);
      chk("err_cnt", int'(err_cnt), e_err);
      chk("ff_vld", int'(first_fail_vld), e_ffv);
      chk("ff_addr", int'(first_fail_addr), e_ffa);
      if (t < t_done && ph == H + 1) {flop_q, flop_qbar} = resp[p];
      else                           {flop_q, flop_qbar} = 2'($urandom);
      if ((t == extra_t && t < t_done) || t == t_done) start = 1'b1;
      if (t == rst_t) begin
        rst_n = 1'b0;
        #1;
        chk_zero("rst_async");
        @(negedge clk);
        chk_zero("rst_held");
        rst_n  = 1'b1;
        m_addr = 0;
        return;
      end
    end
  endtask

  initial begin
    int td;
    for (int i = 0; i < NP; i++) begin rom[i] = '0; resp[i] = '0; end
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;

    // Nominal three-pattern run with a matching cell.
    rom[0] = 6'b000101; rom[1] = 6'b100010; rom[2] = 6'b010001;
    for (int i = 0; i < 3; i++) resp[i] = rom[i][1:0];
    run(3, 0, 0, td);
    chk("nom_done_cycle", td, 19);
    chk("nom_err_cnt", int'(err_cnt), 0);
    chk("nom_ff_vld", int'(first_fail_vld), 0);

    // Cell forces q=0 on pattern 1; start pulsed while busy is ignored.
    resp[1] = 2'b00;
    run(3, 7, 0, td);
`ifdef MIOC_SEQ_STOP_ON_FAIL_EN
    chk("mis_done_cycle", td, 13);
`else
    chk("mis_done_cycle", td, 19);
`endif
    chk("mis_err_cnt", int'(err_cnt), 1);
    chk("mis_ff_vld", int'(first_fail_vld), 1);
    chk("mis_ff_addr", int'(first_fail_addr), 1);

    // Reset in the HOLD of pattern 2, then a clean run from address 0.
    resp[1] = rom[1][1:0];
    run(3, 0, 2 * (H + 2) + 4, td);
    chk("rst_no_done", td, -1);
    run(3, 0, 0, td);
    chk("post_rst_done_cycle", td, 19);

    // Empty run.
    run(0, 0, 0, td);
    chk("empty_done_cycle", td, 1);
    chk("empty_err_cnt", int'(err_cnt), 0);

    // Every pattern fails: counter saturates.
    for (int i = 0; i < 5; i++) begin rom[i] = 6'($urandom); resp[i] = ~rom[i][1:0]; end
    run(5, 0, 0, td);
`ifdef MIOC_SEQ_STOP_ON_FAIL_EN
    chk("sat_err_cnt", int'(err_cnt), 1);
`else
    chk("sat_err_cnt", int'(err_cnt), 3);
`endif
    chk("sat_ff_addr", int'(first_fail_addr), 0);

    // Largest run and randomized runs.
    for (int r = 0; r < 16; r++) begin
      int n;
      for (int i = 0; i < NP; i++) begin
        rom[i]  = 6'($urandom);
        resp[i] = ($urandom_range(0, 4) == 0) ? 2'($urandom) : rom[i][1:0];
      end
      n = (r == 0) ? NP - 1 : int'($urandom_range(0, NP - 1));
      run(n, int'($urandom_range(0, n * (H + 2))), 0, td);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
